// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the iterative shifter (shift_seq_unit).
package shift_pkg;

    localparam int SHIFT_N      = 16;
    localparam int SHIFT_AMNT_W = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single-position step of the working register.
// The rotate path (and the rot port) exists only when SHIFT_ROTATE_EN is defined.
module shift_step_unit import shift_pkg::*; #(
    parameter int N = SHIFT_N
) (
    input  logic [N-1:0] din,
    input  logic         dir,
`ifdef SHIFT_ROTATE_EN
    input  logic         rot,
`endif
    output logic [N-1:0] dout
);

    logic fill_lsb;
    logic fill_msb;

    always_comb begin
        fill_lsb = 1'b0;
        fill_msb = 1'b0;
`ifdef SHIFT_ROTATE_EN
        // On rotate, the bit leaving one end re-enters at the other.
        if (rot) begin
            fill_lsb = din[N-1];
            fill_msb = din[0];
        end
`endif
        if (dir == DIR_RIGHT) begin
            dout = {fill_msb, din[N-1:1]};
        end else begin
            dout = {din[N-2:0], fill_lsb};
        end
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle iterative shifter with a start/done handshake; one bit position per clock.
// Rotate support is compiled in only when SHIFT_ROTATE_EN is defined.
module shift_seq_unit import shift_pkg::*; #(
    parameter int N      = SHIFT_N,
    parameter int AMNT_W = SHIFT_AMNT_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Shift_dir,
    input  logic              Shift_rot,
    input  logic [AMNT_W-1:0] Shift_amnt,
    input  logic [N-1:0]      Reg_read_data_1,
    output logic              Ready,
    output logic              Done,
    output logic [N-1:0]      Shift_out
);

    state_t            state_q, state_d;
    logic [AMNT_W-1:0] count_q, count_d;
    logic [N-1:0]      work_q, work_d;
    logic [N-1:0]      out_q, out_d;
    logic [N-1:0]      step_out;
    logic              dir_q, dir_d;
`ifdef SHIFT_ROTATE_EN
    logic              rot_q, rot_d;
`else
    logic              unused_rot;

    assign unused_rot = Shift_rot;
`endif

    shift_step_unit #(.N(N)) u_step (
        .din  (work_q),
        .dir  (dir_q),
`ifdef SHIFT_ROTATE_EN
        .rot  (rot_q),
`endif
        .dout (step_out)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        work_d  = work_q;
        out_d   = out_q;
        dir_d   = dir_q;
`ifdef SHIFT_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    work_d  = Reg_read_data_1;
                    count_d = Shift_amnt;
                    dir_d   = Shift_dir;
`ifdef SHIFT_ROTATE_EN
                    rot_d   = Shift_rot;
`endif
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (count_q != '0) begin
                    work_d  = step_out;
                    count_d = count_q - 1'b1;
                end else begin
                    // Result register changes only here, so it holds through IDLE/BUSY.
                    out_d   = work_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            work_q  <= '0;
            out_q   <= '0;
            dir_q   <= DIR_LEFT;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            work_q  <= work_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign Ready     = (state_q == ST_IDLE);
    assign Done      = (state_q == ST_DONE);
    assign Shift_out = out_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed cases plus randomized ops against a reference model.
// Honours SHIFT_ROTATE_EN the same way as the design.
module tb_shift_seq_unit;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic        Shift_dir;
    logic        Shift_rot;
    logic [3:0]  Shift_amnt;
    logic [15:0] Reg_read_data_1;
    logic        Ready;
    logic        Done;
    logic [15:0] Shift_out;

    int pass_cnt;
    int check_cnt;

`ifdef SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    shift_seq_unit dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Start           (Start),
        .Shift_dir       (Shift_dir),
        .Shift_rot       (Shift_rot),
        .Shift_amnt      (Shift_amnt),
        .Reg_read_data_1 (Reg_read_data_1),
        .Ready           (Ready),
        .Done            (Done),
        .Shift_out       (Shift_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: whole-word shift/rotate by the full amount in one step.
    function automatic logic [15:0] ref_shift(input logic [15:0] op, input bit dir,
                                              input bit rot, input int amnt);
        int unsigned v;
        int unsigned r;
        bit rot_eff;
        v = op;
        rot_eff = rot && ROT_EN;
        if (!dir) begin
            r = v << amnt;
            if (rot_eff) r = r | (v >> (16 - amnt));
        end else begin
            r = v >> amnt;
            if (rot_eff) r = r | (v << (16 - amnt));
        end
        return r[15:0];
    endfunction

    // Drives one request while idle, scrambles inputs after acceptance, waits (bounded) for Done.
    task automatic run_op(input logic [15:0] op, input bit dir, input bit rot, input logic [3:0] amnt,
                          output int lat, output logic [15:0] res, output time t_acc);
        @(negedge Clk);
        Reg_read_data_1 = op;
        Shift_dir       = dir;
        Shift_rot       = rot;
        Shift_amnt      = amnt;
        Start           = 1'b1;
        @(posedge Clk);
        t_acc = $time;
        #1;
        Start           = 1'b0;
        Reg_read_data_1 = 16'($urandom);
        Shift_dir       = ~dir;
        Shift_rot       = ~rot;
        Shift_amnt      = 4'($urandom);
        lat = -1;
        res = 16'hxxxx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                lat = k;
                res = Shift_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Start = 1'b0; Shift_dir = 1'b0; Shift_rot = 1'b0; Shift_amnt = 4'd0; Reg_read_data_1 = 16'h0;
        #12;
        check_cnt++;
        if (Ready !== 1'b1 || Done !== 1'b0 || Shift_out !== 16'h0)
            $display("[TB] FAIL reset_state: Ready=%b Done=%b Shift_out=%h, need 1 0 0000", Ready, Done, Shift_out);
        else pass_cnt++;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_cnt++;
        if (Ready !== 1'b1 || Done !== 1'b0 || Shift_out !== 16'h0)
            $display("[TB] FAIL after_reset: Ready=%b Done=%b Shift_out=%h, need 1 0 0000", Ready, Done, Shift_out);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        int lat; logic [15:0] res; time t;
        logic [15:0] op_list [5]  = '{16'h0010, 16'h0010, 16'h0010, 16'h0001, 16'h8000};
        bit          dir_list [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0]  amt_list [5] = '{4'd3, 4'd2, 4'd0, 4'd15, 4'd15};
        logic [15:0] exp_list [5] = '{16'h0080, 16'h0004, 16'h0010, 16'h8000, 16'h0001};
        for (int i = 0; i < 5; i++) begin
            run_op(op_list[i], dir_list[i], 1'b0, amt_list[i], lat, res, t);
            check_cnt++;
            if (res !== exp_list[i])
                $display("[TB] FAIL directed_result[%0d]: got %h, need %h", i, res, exp_list[i]);
            else pass_cnt++;
            check_cnt++;
            if (lat !== int'(amt_list[i]) + 2)
                $display("[TB] FAIL directed_latency[%0d]: got %0d cycles, need %0d", i, lat, int'(amt_list[i]) + 2);
            else pass_cnt++;
            @(negedge Clk);
            check_cnt++;
            if (Ready !== 1'b1 || Done !== 1'b0)
                $display("[TB] FAIL directed_ready_after[%0d]: Ready=%b Done=%b, need 1 0", i, Ready, Done);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_busy();
        int lat; int extra_done; logic [15:0] prev;
        // Last directed result is 0x0001 and must hold while the next op runs.
        prev = 16'h0001;
        @(negedge Clk);
        Reg_read_data_1 = 16'h0010; Shift_dir = 1'b0; Shift_rot = 1'b0; Shift_amnt = 4'd3; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(negedge Clk);
        check_cnt++;
        if (Ready !== 1'b0 || Shift_out !== prev)
            $display("[TB] FAIL busy_hold: Ready=%b Shift_out=%h, need 0 %h", Ready, Shift_out, prev);
        else pass_cnt++;
        Reg_read_data_1 = 16'hFFFF; Shift_dir = 1'b1; Shift_amnt = 4'd0; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        lat = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_cnt++;
        if (lat !== 5 || Shift_out !== 16'h0080)
            $display("[TB] FAIL ignore_busy: lat=%0d out=%h, need 5 0080", lat, Shift_out);
        else pass_cnt++;
        extra_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (Done === 1'b1) extra_done++;
        end
        check_cnt++;
        if (extra_done !== 0 || Shift_out !== 16'h0080)
            $display("[TB] FAIL ignore_busy_no_second: extra Done=%0d out=%h, need 0 0080", extra_done, Shift_out);
        else pass_cnt++;
    endtask

    task automatic test_rotate();
        int lat; logic [15:0] res; time t; logic [15:0] expv;
`ifdef SHIFT_ROTATE_EN
        expv = 16'hC000;
`else
        expv = 16'h4000;
`endif
        run_op(16'h8001, 1'b1, 1'b1, 4'd1, lat, res, t);
        check_cnt++;
        if (res !== expv || lat !== 3)
            $display("[TB] FAIL rotate_right: got %h lat %0d, need %h lat 3", res, lat, expv);
        else pass_cnt++;
        run_op(16'h8001, 1'b0, 1'b1, 4'd4, lat, res, t);
        check_cnt++;
        if (res !== ref_shift(16'h8001, 1'b0, 1'b1, 4))
            $display("[TB] FAIL rotate_left: got %h, need %h", res, ref_shift(16'h8001, 1'b0, 1'b1, 4));
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat; logic [15:0] res; time t;
        logic [15:0] op; bit dir; bit rot; logic [3:0] amt;
        for (int i = 0; i < 24; i++) begin
            op  = 16'($urandom);
            dir = 1'($urandom);
            rot = 1'($urandom);
            amt = 4'($urandom);
            run_op(op, dir, rot, amt, lat, res, t);
            check_cnt++;
            if (res !== ref_shift(op, dir, rot, int'(amt)) || lat !== int'(amt) + 2)
                $display("[TB] FAIL random[%0d] op=%h dir=%0d rot=%0d amt=%0d: got %h lat %0d, need %h lat %0d",
                         i, op, dir, rot, amt, res, lat, ref_shift(op, dir, rot, int'(amt)), int'(amt) + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic [15:0] r1, r2; time t1, t2;
        run_op(16'hA5A5, 1'b0, 1'b0, 4'd2, lat1, r1, t1);
        run_op(16'h0F0F, 1'b1, 1'b0, 4'd5, lat2, r2, t2);
        check_cnt++;
        if (r1 !== 16'h9694 || r2 !== 16'h0078)
            $display("[TB] FAIL b2b_results: got %h %h, need 9694 0078", r1, r2);
        else pass_cnt++;
        check_cnt++;
        if ((t2 - t1) / 10 !== 5)
            $display("[TB] FAIL b2b_period: got %0d cycles, need 5", (t2 - t1) / 10);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_busy();
        int done_seen;
        @(negedge Clk);
        Reg_read_data_1 = 16'h0001; Shift_dir = 1'b0; Shift_rot = 1'b0; Shift_amnt = 4'd15; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check_cnt++;
        if (Ready !== 1'b1 || Done !== 1'b0 || Shift_out !== 16'h0)
            $display("[TB] FAIL reset_mid_busy: Ready=%b Done=%b out=%h, need 1 0 0000", Ready, Done, Shift_out);
        else pass_cnt++;
        @(negedge Clk);
        Reset_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge Clk);
            if (Done === 1'b1) done_seen++;
        end
        check_cnt++;
        if (done_seen !== 0 || Ready !== 1'b1)
            $display("[TB] FAIL reset_no_done: Done pulses=%0d Ready=%b, need 0 1", done_seen, Ready);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        check_cnt = 0;
        test_reset();
        test_directed();
        test_ignore_busy();
        test_rotate();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
